uart_wb_cmd_bridge: RTL and testbench
=====================================

UART_WB_CMD_BRIDGE -- requirements
Module: uart_wb_cmd_bridge

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 255: clock cycles a Wishbone access waits for ack before it aborts.
REQ-002 SHALL have ports, one per line (name, direction, width, meaning):
 clk  in  1  system clock (12 MHz board clock), single clock domain
 i_reset_n  in  1  asynchronous active-low reset
 i_rx_data  in  8  received byte from the UART receiver
 i_rx_rxne  in  1  receiver holds an unread byte
 o_rx_clear  out  1  one-cycle pulse; byte consumed
 o_tx_data  out  8  byte to the UART transmitter
 o_tx_valid  out  1  one-cycle pulse; start transmit
 i_tx_busy  in  1  transmitter busy
 o_wb_cyc, o_wb_stb, o_wb_we  out  1 each  Wishbone classic master controls
 o_wb_adr  out  16  Wishbone address
 o_wb_dat  out  16  Wishbone write data
 i_wb_dat  in  16  Wishbone read data
 i_wb_ack  in  1  Wishbone acknowledge

Function
REQ-003 SHALL decode an ASCII command stream: 'A' selects the address field; 'D' selects the data field; 'R' issues a read; 'W' issues a write.
REQ-004 SHALL treat only '0'-'9' and 'a'-'f' as hex digits; a digit shifts the selected 16-bit field left by 4 and inserts the nibble; bits above 16 are discarded.
REQ-005 SHALL ignore hex digits when no field is selected; 'R'/'W' clear the field selection; all other bytes are consumed and ignored.
REQ-006 SHALL use the FSM states IDLE, CONSUME, WB_REQ, WB_WAIT, TX_SEND, TX_GAP.
REQ-007 IDLE: when i_rx_rxne=1, SHALL pulse o_rx_clear for exactly one cycle and go to CONSUME; it SHALL NOT clear while in any other state.
REQ-008 CONSUME: SHALL decode the latched byte in one cycle, then go to WB_REQ for 'R'/'W' and to IDLE otherwise.
REQ-009 WB_REQ: SHALL assert cyc=stb=1, with we=1 for 'W', adr=address field, dat=data field, and go to WB_WAIT the next cycle.
REQ-010 WB_WAIT: on i_wb_ack=1, SHALL drop cyc/stb in the same edge, capture i_wb_dat on reads, and go to TX_SEND.
REQ-011 SHALL abort the access after TIMEOUT_CYC cycles in WB_WAIT without ack (cyc/stb low) and send the response "E\n".
REQ-012 SHALL send these responses: read = 4 lowercase hex digits, MSB nibble first, then 0x0A; write = "K\n".
REQ-013 TX_SEND: SHALL pulse o_tx_valid with the current byte only when i_tx_busy=0, then go to TX_GAP.
REQ-014 TX_GAP: SHALL wait 2 cycles, then wait for i_tx_busy=0; it SHALL go to TX_SEND for the next byte, or to IDLE after the last byte.
REQ-015 o_tx_valid and o_rx_clear SHALL never be high for two consecutive cycles.
REQ-016 Bytes that arrive outside IDLE SHALL remain in the receiver; overrun handling is the receiver's.
REQ-017 The field registers SHALL hold their values across commands, so 'R' repeated re-reads the same address.

Reset
REQ-018 While i_reset_n=0, the block SHALL go asynchronously to IDLE with every output 0; address field, data field, read capture, field selection and timeout counter SHALL be 0.
REQ-019 Reset during WB_WAIT or TX_* SHALL drop cyc/stb/o_tx_valid immediately; no partial response SHALL resume after reset.

Configuration
REQ-020 With macro WB_BRIDGE_AUTOINC_EN defined, the address field SHALL increment by 1 (wrapping 0xFFFF->0x0000) after every acked 'R' or 'W'; the increment SHALL NOT occur on timeout.
REQ-021 Without WB_BRIDGE_AUTOINC_EN, the address field SHALL change only through hex digits after 'A'.

Verification
REQ-022 Bytes "A3410R", slave returns 0xBEEF on ack after 3 cycles -> one read at adr 0x3410, TX bytes 'b','e','e','f',0x0A.
REQ-023 Bytes "A12345D00ffW" -> adr 0x2345 (overflow discarded), one write of dat 0x00FF with we=1, TX "K\n".
REQ-024 Bytes "A10R" with no ack -> cyc high for exactly 255 cycles, then low, TX "E\n", address unchanged.
REQ-025 i_tx_busy held high for 500 cycles during a response -> no o_tx_valid while busy, bytes in order, none dropped.
REQ-026 Reset asserted in WB_WAIT -> cyc/stb low before the next edge, all outputs 0; after release "R" reads adr 0x0000.
REQ-027 With WB_BRIDGE_AUTOINC_EN, bytes "AffffRR" -> reads at 0xFFFF then 0x0000.

Source files
------------

// File: rtl/uart_wb_cmd_bridge.sv
// ASCII command bridge: UART bytes select address/data fields and launch single Wishbone classic accesses.
// Optional feature: define WB_BRIDGE_AUTOINC_EN to step the address field after every acknowledged access.
module uart_wb_cmd_bridge #(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        i_reset_n,
  input  logic [7:0]  i_rx_data,
  input  logic        i_rx_rxne,
  output logic        o_rx_clear,
  output logic [7:0]  o_tx_data,
  output logic        o_tx_valid,
  input  logic        i_tx_busy,
  output logic        o_wb_cyc,
  output logic        o_wb_stb,
  output logic        o_wb_we,
  output logic [15:0] o_wb_adr,
  output logic [15:0] o_wb_dat,
  input  logic [15:0] i_wb_dat,
  input  logic        i_wb_ack
);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0, CONSUME = 3'd1, WB_REQ = 3'd2, WB_WAIT = 3'd3, TX_SEND = 3'd4, TX_GAP = 3'd5
  } state_t;
  typedef enum logic [1:0] {SEL_NONE = 2'd0, SEL_ADDR = 2'd1, SEL_DATA = 2'd2} sel_t;
  typedef enum logic [1:0] {RSP_READ = 2'd0, RSP_WRITE = 2'd1, RSP_ERR = 2'd2} rsp_t;

  // Bit 4 flags a valid lowercase hex digit, bits 3:0 carry its nibble.
  function automatic logic [4:0] hex_val(input logic [7:0] c);
    if (c >= 8'h30 && c <= 8'h39) hex_val = {1'b1, c[3:0]};
    else if (c >= 8'h61 && c <= 8'h66) hex_val = {1'b1, c[3:0] + 4'd9};
    else hex_val = 5'd0;
  endfunction

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    if (n < 4'd10) hex_char = 8'h30 + {4'h0, n};
    else hex_char = 8'h57 + {4'h0, n};
  endfunction

  function automatic logic [7:0] rsp_byte(input rsp_t kind, input logic [2:0] idx, input logic [15:0] rd);
    logic [7:0] b;
    case (kind)
      RSP_READ: begin
        case (idx)
          3'd0:    b = hex_char(rd[15:12]);
          3'd1:    b = hex_char(rd[11:8]);
          3'd2:    b = hex_char(rd[7:4]);
          3'd3:    b = hex_char(rd[3:0]);
          default: b = 8'h0A;
        endcase
      end
      RSP_WRITE: b = (idx == 3'd0) ? 8'h4B : 8'h0A;
      default:   b = (idx == 3'd0) ? 8'h45 : 8'h0A;
    endcase
    return b;
  endfunction

  state_t         state_r, state_s;
  sel_t           sel_r, sel_s;
  rsp_t           rsp_r, rsp_s;
  logic [7:0]     byte_r, byte_s, tx_data_r, tx_data_s;
  logic [15:0]    addr_r, addr_s, data_r, data_s, rd_r, rd_s;
  logic [2:0]     idx_r, idx_s, last_s;
  logic [1:0]     gap_r, gap_s;
  logic [TW-1:0]  timer_r, timer_s;
  logic           cyc_r, cyc_s, we_r, we_s, rx_clear_r, rx_clear_s, tx_valid_r, tx_valid_s;
  logic [4:0]     hv_s;

  // Next-state and next-output logic for the command FSM.
  always_comb begin
    state_s    = state_r;
    sel_s      = sel_r;
    rsp_s      = rsp_r;
    byte_s     = byte_r;
    tx_data_s  = tx_data_r;
    addr_s     = addr_r;
    data_s     = data_r;
    rd_s       = rd_r;
    idx_s      = idx_r;
    gap_s      = gap_r;
    timer_s    = timer_r;
    cyc_s      = cyc_r;
    we_s       = we_r;
    rx_clear_s = 1'b0;
    tx_valid_s = 1'b0;
    hv_s       = hex_val(byte_r);
    last_s     = (rsp_r == RSP_READ) ? 3'd4 : 3'd1;
    case (state_r)
      IDLE: begin
        if (i_rx_rxne) begin
          rx_clear_s = 1'b1;
          byte_s     = i_rx_data;
          state_s    = CONSUME;
        end else begin
          state_s = IDLE;
        end
      end
      CONSUME: begin
        state_s = IDLE;
        case (byte_r)
          8'h41: sel_s = SEL_ADDR;
          8'h44: sel_s = SEL_DATA;
          8'h52, 8'h57: begin
            sel_s   = SEL_NONE;
            we_s    = (byte_r == 8'h57);
            cyc_s   = 1'b1;
            timer_s = '0;
            state_s = WB_REQ;
          end
          default: begin
            if (hv_s[4] && sel_r == SEL_ADDR) addr_s = {addr_r[11:0], hv_s[3:0]};
            else if (hv_s[4] && sel_r == SEL_DATA) data_s = {data_r[11:0], hv_s[3:0]};
            else sel_s = sel_r;
          end
        endcase
      end
      WB_REQ: begin
        // The request cycle counts toward the timeout budget of cyc-high cycles.
        timer_s = TW'(1);
        state_s = WB_WAIT;
      end
      WB_WAIT: begin
        if (i_wb_ack) begin
          cyc_s   = 1'b0;
          we_s    = 1'b0;
          idx_s   = 3'd0;
          state_s = TX_SEND;
          if (we_r) begin
            rsp_s = RSP_WRITE;
          end else begin
            rsp_s = RSP_READ;
            rd_s  = i_wb_dat;
          end
`ifdef WB_BRIDGE_AUTOINC_EN
          addr_s = addr_r + 16'd1;
`else
          addr_s = addr_r;
`endif
        end else if (timer_r >= TW'(TIMEOUT_CYC - 1)) begin
          cyc_s   = 1'b0;
          we_s    = 1'b0;
          rsp_s   = RSP_ERR;
          idx_s   = 3'd0;
          state_s = TX_SEND;
        end else begin
          timer_s = timer_r + TW'(1);
        end
      end
      TX_SEND: begin
        if (!i_tx_busy) begin
          tx_valid_s = 1'b1;
          tx_data_s  = rsp_byte(rsp_r, idx_r, rd_r);
          gap_s      = 2'd0;
          state_s    = TX_GAP;
        end else begin
          state_s = TX_SEND;
        end
      end
      TX_GAP: begin
        // Two settle cycles give the transmitter time to raise busy for the byte just sent.
        if (gap_r != 2'd2) begin
          gap_s = gap_r + 2'd1;
        end else if (!i_tx_busy) begin
          if (idx_r == last_s) begin
            state_s = IDLE;
          end else begin
            idx_s   = idx_r + 3'd1;
            state_s = TX_SEND;
          end
        end else begin
          state_s = TX_GAP;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // State and registered outputs; reset clears everything asynchronously.
  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_r    <= IDLE;
      sel_r      <= SEL_NONE;
      rsp_r      <= RSP_READ;
      byte_r     <= 8'h00;
      tx_data_r  <= 8'h00;
      addr_r     <= 16'h0000;
      data_r     <= 16'h0000;
      rd_r       <= 16'h0000;
      idx_r      <= 3'd0;
      gap_r      <= 2'd0;
      timer_r    <= '0;
      cyc_r      <= 1'b0;
      we_r       <= 1'b0;
      rx_clear_r <= 1'b0;
      tx_valid_r <= 1'b0;
    end else begin
      state_r    <= state_s;
      sel_r      <= sel_s;
      rsp_r      <= rsp_s;
      byte_r     <= byte_s;
      tx_data_r  <= tx_data_s;
      addr_r     <= addr_s;
      data_r     <= data_s;
      rd_r       <= rd_s;
      idx_r      <= idx_s;
      gap_r      <= gap_s;
      timer_r    <= timer_s;
      cyc_r      <= cyc_s;
      we_r       <= we_s;
      rx_clear_r <= rx_clear_s;
      tx_valid_r <= tx_valid_s;
    end
  end

  assign o_rx_clear = rx_clear_r;
  assign o_tx_valid = tx_valid_r;
  assign o_tx_data  = tx_data_r;
  assign o_wb_cyc   = cyc_r;
  assign o_wb_stb   = cyc_r;
  assign o_wb_we    = we_r;
  assign o_wb_adr   = addr_r;
  assign o_wb_dat   = data_r;
endmodule

// File: tb/tb_uart_wb_cmd_bridge.sv
// Directed bench for uart_wb_cmd_bridge with a UART receiver/transmitter model and a Wishbone slave model.
module tb_uart_wb_cmd_bridge;
`ifdef WB_BRIDGE_AUTOINC_EN
  localparam logic [15:0] AI = 16'd1;
`else
  localparam logic [15:0] AI = 16'd0;
`endif

  logic        clk = 1'b0;
  logic        i_reset_n = 1'b0;
  logic [7:0]  i_rx_data = 8'h00;
  logic        i_rx_rxne = 1'b0;
  logic        o_rx_clear;
  logic [7:0]  o_tx_data;
  logic        o_tx_valid;
  logic        i_tx_busy;
  logic        o_wb_cyc, o_wb_stb, o_wb_we;
  logic [15:0] o_wb_adr, o_wb_dat;
  logic [15:0] i_wb_dat = 16'h0000;
  logic        i_wb_ack = 1'b0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  uart_wb_cmd_bridge #(.TIMEOUT_CYC(255)) dut (
    .clk(clk), .i_reset_n(i_reset_n),
    .i_rx_data(i_rx_data), .i_rx_rxne(i_rx_rxne), .o_rx_clear(o_rx_clear),
    .o_tx_data(o_tx_data), .o_tx_valid(o_tx_valid), .i_tx_busy(i_tx_busy),
    .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we),
    .o_wb_adr(o_wb_adr), .o_wb_dat(o_wb_dat), .i_wb_dat(i_wb_dat), .i_wb_ack(i_wb_ack)
  );

  // Wishbone slave: acks on the ack_delay-th cyc-high cycle and records each access.
  bit          ack_en = 1'b1;
  int          ack_delay = 3;
  logic [15:0] rdata = 16'h0000;
  int          cyc_len = 0, last_cyc_len = 0, acc_cnt = 0;
  logic [15:0] acc_adr = 16'h0000, acc_dat = 16'h0000;
  logic        acc_we = 1'b0, acc_stb = 1'b0;
  always @(negedge clk) begin
    i_wb_ack = 1'b0;
    if (o_wb_cyc) begin
      if (cyc_len == 0) begin
        acc_cnt++;
        acc_adr = o_wb_adr;
        acc_dat = o_wb_dat;
        acc_we  = o_wb_we;
        acc_stb = o_wb_stb;
      end
      cyc_len++;
      if (ack_en && cyc_len == ack_delay) begin
        i_wb_ack = 1'b1;
        i_wb_dat = rdata;
      end
    end else if (cyc_len != 0) begin
      last_cyc_len = cyc_len;
      cyc_len = 0;
    end
  end

  // UART transmitter: goes busy after each accepted byte; flags protocol violations.
  logic [7:0] tx_q[$];
  int   busy_cnt = 0, viol = 0;
  bit   force_busy = 1'b0, prev_valid = 1'b0, prev_clear = 1'b0;
  logic busy_seen = 1'b0;
  assign i_tx_busy = force_busy || (busy_cnt != 0);
  always @(posedge clk) busy_seen <= i_tx_busy;
  always @(negedge clk) begin
    if (o_tx_valid) begin
      if (busy_seen) viol++;
      if (prev_valid) viol++;
      tx_q.push_back(o_tx_data);
      busy_cnt = 4;
    end else if (busy_cnt != 0) begin
      busy_cnt--;
    end
    if (o_rx_clear && prev_clear) viol++;
    prev_valid = o_tx_valid;
    prev_clear = o_rx_clear;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit seen = 1'b0;
    @(negedge clk);
    i_rx_data = b;
    i_rx_rxne = 1'b1;
    for (int k = 0; k < 3000 && !seen; k++) begin
      @(negedge clk);
      if (o_rx_clear) seen = 1'b1;
    end
    i_rx_rxne = 1'b0;
    chk("rx_clear_seen", {63'd0, seen}, 64'd1);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic expect_tx(input string tag, input int n, input logic [39:0] exp);
    for (int k = 0; k < 4000 && tx_q.size() < n; k++) @(negedge clk);
    repeat (12) @(negedge clk);
    chk({tag, "_count"}, 64'(tx_q.size()), 64'(n));
    for (int i = 0; i < n; i++)
      chk($sformatf("%s_byte%0d", tag, i), {56'd0, tx_q[i]}, {56'd0, exp[8*(n-1-i) +: 8]});
    tx_q.delete();
  endtask

  logic [15:0] adr_tmo, exp_adr;
  int          held;

  initial begin
    #5_000_000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_outputs", {19'd0, o_rx_clear, o_tx_valid, o_tx_data, o_wb_cyc, o_wb_stb, o_wb_we, o_wb_adr, o_wb_dat}, 64'd0);
    i_reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Basic read: slave acks on the 3rd cycle with 0xBEEF.
    rdata = 16'hBEEF;
    send_str("A3410R");
    expect_tx("rd_beef", 5, {8'h62, 8'h65, 8'h65, 8'h66, 8'h0A});
    chk("rd_acc_cnt", 64'(acc_cnt), 64'd1);
    chk("rd_adr", {48'd0, acc_adr}, {48'd0, 16'h3410});
    chk("rd_we_stb", {62'd0, acc_we, acc_stb}, {62'd0, 1'b0, 1'b1});
    chk("rd_cyc_len", 64'(last_cyc_len), 64'd3);

    // Write with address overflow discarded.
    send_str("A12345D00ffW");
    expect_tx("wr_k", 2, {24'd0, 8'h4B, 8'h0A});
    chk("wr_adr", {48'd0, acc_adr}, {48'd0, 16'h2345});
    chk("wr_dat", {48'd0, acc_dat}, {48'd0, 16'h00FF});
    chk("wr_we", {63'd0, acc_we}, 64'd1);

    // Timeout: no ack, cyc high exactly 255 cycles, "E\n", address unchanged.
    adr_tmo = ((16'h2345 + AI) << 8) | 16'h0010;
    ack_en = 1'b0;
    send_str("A10R");
    expect_tx("tmo_e", 2, {24'd0, 8'h45, 8'h0A});
    chk("tmo_cyc_len", 64'(last_cyc_len), 64'd255);
    chk("tmo_acc_adr", {48'd0, acc_adr}, {48'd0, adr_tmo});
    chk("tmo_adr_kept", {48'd0, o_wb_adr}, {48'd0, adr_tmo});
    ack_en = 1'b1;

    // Digits without a selected field are ignored; 'R' re-reads the held address.
    rdata = 16'h7e01;
    send_str("77R");
    expect_tx("reread", 5, {8'h37, 8'h65, 8'h30, 8'h31, 8'h0A});
    chk("reread_adr", {48'd0, acc_adr}, {48'd0, adr_tmo});
    exp_adr = adr_tmo + AI;

    // Uppercase B/C/E/F are not hex digits.
    send_str("DBCEF9W");
    expect_tx("wr2_k", 2, {24'd0, 8'h4B, 8'h0A});
    chk("wr2_dat", {48'd0, acc_dat}, {48'd0, 16'h0FF9});
    chk("wr2_adr", {48'd0, acc_adr}, {48'd0, exp_adr});
    exp_adr = exp_adr + AI;

    // Transmitter held busy for 500 cycles mid-response.
    rdata = 16'h0a5c;
    send_str("R");
    for (int k = 0; k < 4000 && tx_q.size() < 1; k++) @(negedge clk);
    force_busy = 1'b1;
    held = tx_q.size();
    repeat (500) @(negedge clk);
    chk("busy_no_valid", 64'(tx_q.size()), 64'(held));
    force_busy = 1'b0;
    expect_tx("busy_rd", 5, {8'h30, 8'h61, 8'h35, 8'h63, 8'h0A});
    chk("busy_adr", {48'd0, acc_adr}, {48'd0, exp_adr});

    // Reset while waiting for ack.
    ack_en = 1'b0;
    send_str("R");
    repeat (5) @(negedge clk);
    chk("rst_in_wait_cyc", {63'd0, o_wb_cyc}, 64'd1);
    @(posedge clk);
    #2 i_reset_n = 1'b0;
    #1 chk("rst_async_outputs", {19'd0, o_rx_clear, o_tx_valid, o_tx_data, o_wb_cyc, o_wb_stb, o_wb_we, o_wb_adr, o_wb_dat}, 64'd0);
    repeat (3) @(negedge clk);
    i_reset_n = 1'b1;
    ack_en = 1'b1;
    repeat (20) @(negedge clk);
    chk("rst_no_resume", 64'(tx_q.size()), 64'd0);
    rdata = 16'h1234;
    send_str("R");
    expect_tx("rst_rd", 5, {8'h31, 8'h32, 8'h33, 8'h34, 8'h0A});
    chk("rst_rd_adr", {48'd0, acc_adr}, 64'd0);

    // Address wrap at 0xFFFF (increment only when the option is built in).
    rdata = 16'h9d07;
    send_str("AffffR");
    expect_tx("wrap_rd1", 5, {8'h39, 8'h64, 8'h30, 8'h37, 8'h0A});
    chk("wrap_adr1", {48'd0, acc_adr}, {48'd0, 16'hFFFF});
    send_str("R");
    expect_tx("wrap_rd2", 5, {8'h39, 8'h64, 8'h30, 8'h37, 8'h0A});
    chk("wrap_adr2", {48'd0, acc_adr}, {48'd0, 16'hFFFF + AI});

    chk("protocol_violations", 64'(viol), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
